// File: rtl/pbs_rng_move_unit.sv
// rtl/pbs_rng_move_unit.sv - LFSR random source, trainer move mux, move table and hit compare
module pbs_rng_move_unit #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stop,
    input  logic       actr,
    input  logic [1:0] p_move,
    output logic [1:0] ai_move,
    output logic [4:0] accu_roll,
    output logic [1:0] sel_move,
    output logic [4:0] dmg,
    output logic [4:0] accu,
    output logic       hit
);

    logic [15:0] lfsr;

    // Galois form: shift right, fold the taps in when the bit shifted out is 1
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= SEED;
        end else if (!stop) begin
            if (lfsr[0]) begin
                lfsr <= (lfsr >> 1) ^ TAPS;
            end else begin
                lfsr <= lfsr >> 1;
            end
        end
    end

    assign ai_move   = lfsr[1:0];
    assign accu_roll = {1'b0, lfsr[5:2]};

    // Mux ignores stop, so a frozen LFSR can hand the AI the same move twice
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_move <= 2'd0;
        end else begin
            sel_move <= actr ? ai_move : p_move;
        end
    end

    always_comb begin
        dmg  = 5'd3;
        accu = 5'd15;
        case (sel_move)
            2'd0: begin dmg = 5'd3;  accu = 5'd15; end
            2'd1: begin dmg = 5'd5;  accu = 5'd12; end
            2'd2: begin dmg = 5'd8;  accu = 5'd8;  end
            2'd3: begin dmg = 5'd12; accu = 5'd4;  end
            default: begin dmg = 5'd3; accu = 5'd15; end
        endcase
    end

    assign hit = (accu >= accu_roll);

endmodule

// File: tb/tb_pbs_rng_move_unit.sv
// tb/tb_pbs_rng_move_unit.sv - directed vector bench for pbs_rng_move_unit
module tb_pbs_rng_move_unit;

    logic       clk;
    logic       rst;
    logic       stop;
    logic       actr;
    logic [1:0] p_move;
    logic [1:0] ai_move;
    logic [4:0] accu_roll;
    logic [1:0] sel_move;
    logic [4:0] dmg;
    logic [4:0] accu;
    logic       hit;

    int checks;
    int failures;

    pbs_rng_move_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stop      (stop),
        .actr      (actr),
        .p_move    (p_move),
        .ai_move   (ai_move),
        .accu_roll (accu_roll),
        .sel_move  (sel_move),
        .dmg       (dmg),
        .accu      (accu),
        .hit       (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stop;
        logic        actr;
        logic [1:0]  p_move;
        logic [15:0] exp_lfsr;
        logic [1:0]  exp_ai;
        logic [4:0]  exp_roll;
        logic [1:0]  exp_sel;
        logic [4:0]  exp_dmg;
        logic [4:0]  exp_accu;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic a, input logic [1:0] p);
        rst = r;
        stop = s;
        actr = a;
        p_move = p;
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        drive(1'b0, 1'b0, 1'b0, 2'd0);

        //          rst   stop  actr  p     lfsr      ai     roll   sel    dmg     accu    hit
        vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'hACE1, 2'd1, 5'd8,  2'd0, 5'd3,  5'd15, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'hACE1, 2'd1, 5'd8,  2'd0, 5'd3,  5'd15, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 2'd2, 16'hE270, 2'd0, 5'd12, 2'd2, 5'd8,  5'd8,  1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 2'd3, 16'h7138, 2'd0, 5'd14, 2'd3, 5'd12, 5'd4,  1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 2'd0, 16'h7138, 2'd0, 5'd14, 2'd0, 5'd3,  5'd15, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd1, 16'h389C, 2'd0, 5'd7,  2'd1, 5'd5,  5'd12, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 2'd3, 16'h1C4E, 2'd2, 5'd3,  2'd0, 5'd3,  5'd15, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 2'd0, 16'h0E27, 2'd3, 5'd9,  2'd2, 5'd8,  5'd8,  1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 2'd0, 16'hB313, 2'd3, 5'd4,  2'd3, 5'd12, 5'd4,  1'b1};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 2'd3, 16'hACE1, 2'd1, 5'd8,  2'd0, 5'd3,  5'd15, 1'b1};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].stop, vecs[i].actr, vecs[i].p_move);
            tick();
            chk($sformatf("v%0d_lfsr", i), dut.lfsr, vecs[i].exp_lfsr);
            chk($sformatf("v%0d_ai", i), {14'd0, ai_move}, {14'd0, vecs[i].exp_ai});
            chk($sformatf("v%0d_roll", i), {11'd0, accu_roll}, {11'd0, vecs[i].exp_roll});
            chk($sformatf("v%0d_sel", i), {14'd0, sel_move}, {14'd0, vecs[i].exp_sel});
            chk($sformatf("v%0d_dmg", i), {11'd0, dmg}, {11'd0, vecs[i].exp_dmg});
            chk($sformatf("v%0d_accu", i), {11'd0, accu}, {11'd0, vecs[i].exp_accu});
            chk($sformatf("v%0d_hit", i), {15'd0, hit}, {15'd0, vecs[i].exp_hit});
        end

        // Freeze right after reset, then release for one step
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'd0);
            tick();
            chk($sformatf("freeze%0d_lfsr", i), dut.lfsr, 16'hACE1);
            chk($sformatf("freeze%0d_ai", i), {14'd0, ai_move}, 16'd1);
            chk($sformatf("freeze%0d_roll", i), {11'd0, accu_roll}, 16'd8);
        end
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        tick();
        chk("unfreeze_lfsr", dut.lfsr, 16'hE270);

        // AI select directly after reset picks the seed's move 01
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 2'd3);
        tick();
        chk("ai_first_sel", {14'd0, sel_move}, 16'd1);
        chk("ai_first_dmg", {11'd0, dmg}, 16'd5);
        chk("ai_first_accu", {11'd0, accu}, 16'd12);

        // Reset mid-run
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 2'd3);
        for (int i = 0; i < 10; i++) tick();
        chk("midrun_sel", {14'd0, sel_move}, 16'd3);
        drive(1'b0, 1'b0, 1'b0, 2'd3);
        tick();
        chk("midreset_lfsr", dut.lfsr, 16'hACE1);
        chk("midreset_sel", {14'd0, sel_move}, 16'd0);

        // Full period: back to the seed after exactly 65535 steps, never zero
        begin
            int  cnt;
            bit  zero_seen;
            cnt = 0;
            zero_seen = 1'b0;
            drive(1'b1, 1'b0, 1'b0, 2'd0);
            do begin
                tick();
                cnt++;
                if (dut.lfsr == 16'h0000) zero_seen = 1'b1;
            end while (dut.lfsr != 16'hACE1 && cnt < 70000);
            chk("period_len", cnt[15:0], 16'hFFFF);
            chk("period_len_hi", cnt[31:16], 16'd0);
            chk("never_zero", {15'd0, zero_seen}, 16'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pbs_rng_move_unit.md
Name: pbs_rng_move_unit

Overview:
- Random-source and move-decode front end of the battle datapath.
- Contains a 16-bit Galois LFSR that replaces the ring-oscillator random bits, plus a registered trainer mux selecting the player move or the random AI move.
- Also contains a combinational move table giving damage/accuracy, and a hit comparator.
- Feeds the HP update logic; the HP update logic is not part of this block.

Parameters:
- SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero.
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- stop  in  1  1 = freeze the LFSR (hold value); 0 = advance every cycle.
- actr  in  1  acting trainer: 0 = player, 1 = AI.
- p_move  in  2  player-selected move index.
- ai_move  out  2  random AI move = lfsr[1:0].
- accu_roll  out  5  accuracy roll = {1'b0, lfsr[5:2]}, range 0..15.
- sel_move  out  2  registered selected move index.
- dmg  out  5  damage of sel_move.
- accu  out  5  accuracy threshold of sel_move.
- hit  out  1  1 when accu >= accu_roll (unsigned compare).

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst=0 at a clk edge): lfsr <= SEED and sel_move <= 0, regardless of stop or actr.
- After reset, outputs are: ai_move=01, accu_roll=8, dmg=3, accu=15, hit=1.
- LFSR step when rst=1 and stop=0:
  - if lfsr[0]=1: lfsr <= (lfsr>>1) ^ TAPS
  - else: lfsr <= lfsr>>1
- When stop=1, lfsr holds its value.
- The LFSR never reaches 0 from a nonzero seed. Its period is 65535.
- Trainer mux (registered, every edge when rst=1, independent of stop):
  - sel_move <= actr ? ai_move : p_move
  - ai_move is the pre-edge LFSR value.
- Latency: p_move/actr to sel_move/dmg/accu is 1 cycle.
- ai_move, accu_roll and hit are combinational from current state.
- Move table (combinational from sel_move), dmg/accu:
  - 0: 3/15
  - 1: 5/12
  - 2: 8/8
  - 3: 12/4
- dmg and accu bit 4 is always 0. All values are unsigned.
- hit: accu is compared with accu_roll, both zero-extended to 5 bits. accu=15 always hits.
- Simultaneous stop=1 and actr=1: the mux samples the frozen ai_move, so a repeated AI selection is possible by design.
- Reset mid-operation: the next edge restores SEED and sel_move=0. Nothing else in the block retains state.

Test Plan:
- Reset with rst=0 for 2 cycles, stop=0 -> lfsr=ACE1, ai_move=01, accu_roll=8, sel_move=0, dmg=3, accu=15, hit=1.
- Release reset, stop=0, run 1 cycle -> lfsr=E270, ai_move=00, accu_roll=12. One more cycle -> lfsr=7138, ai_move=00, accu_roll=14.
- Freeze: after reset set stop=1 for 5 cycles -> lfsr stays ACE1, ai_move=01, accu_roll=8 throughout. Then stop=0, one cycle -> E270.
- Player select: actr=0, p_move=2 -> after one edge sel_move=2, dmg=8, accu=8. With accu_roll=12, hit=0. Then p_move=3 -> dmg=12, accu=4.
- AI select: directly after reset, actr=1, stop=0 -> after first edge sel_move=01 (pre-edge ai_move), dmg=5, accu=12.
- Reset mid-run: after 10 running cycles with sel_move=3, pulse rst=0 for one edge -> lfsr=ACE1, sel_move=0. Also check 65535-cycle period: lfsr returns to ACE1 and is never 0.
